// File: rtl/avalon_block_read_master.sv
// Avalon-MM block read master with a checksum accumulator.
// NIOS programs base/length through a 4-register slave port and starts the
// engine. The engine reads consecutive 32-bit words one at a time, sums them
// modulo 2^32 and raises a sticky level interrupt when the block is finished.
module avalon_block_read_master #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 read,
    input  logic                 write,
    output logic [31:0]          readdata,
    input  logic [31:0]          writedata,
    output logic [31:0]          master_address,
    output logic                 master_read,
    input  logic                 master_waitrequest,
    input  logic [31:0]          master_readdata,
    input  logic                 master_readdatavalid,
    output logic                 done_irq
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [31:0]            base_q, base_d;
    logic [LEN_WIDTH-1:0]   length_q, length_d;
    logic [LEN_WIDTH-1:0]   count_q, count_d;
    logic [31:0]            sum_q, sum_d;
    logic [31:0]            addr_q, addr_d;
    logic                   mread_q, mread_d;
    logic                   irq_q, irq_d;
    logic [31:0]            rdata_q, rdata_d;

    logic                   wr_s;
    logic                   rd_s;
    logic                   busy_s;
    logic                   start_s;
    logic                   irq_clr_s;
    logic [LEN_WIDTH-1:0]   count_inc_s;

    // Decode slave strobes; start is only honoured when the engine is idle.
    always_comb begin
        wr_s        = chipselect & write;
        rd_s        = chipselect & read;
        busy_s      = (state_q != ST_IDLE);
        start_s     = wr_s && (address == 2'd2) && writedata[0] && !busy_s;
        irq_clr_s   = wr_s && (address == 2'd2) && writedata[1];
        count_inc_s = count_q + LEN_ONE;
    end

    // Next-state logic: config registers, FSM, master outputs and interrupt.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        length_d = length_q;
        count_d  = count_q;
        sum_d    = sum_q;
        addr_d   = addr_q;
        mread_d  = mread_q;
        irq_d    = irq_q;

        if (wr_s && !busy_s && (address == 2'd0)) begin
            base_d = {writedata[31:2], 2'b00};
        end else begin
            base_d = base_q;
        end

        if (wr_s && !busy_s && (address == 2'd1)) begin
            length_d = writedata[LEN_WIDTH-1:0];
        end else begin
            length_d = length_q;
        end

        // Clear is evaluated first so the DONE-cycle set below overrides it.
        if (irq_clr_s) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    sum_d   = 32'd0;
                    count_d = LEN_ZERO;
                    addr_d  = base_q;
                    if (length_q == LEN_ZERO) begin
                        state_d = ST_DONE;
                        mread_d = 1'b0;
                    end else begin
                        state_d = ST_ISSUE;
                        mread_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!master_waitrequest) begin
                    state_d = ST_WAIT_DATA;
                    mread_d = 1'b0;
                end else begin
                    state_d = ST_ISSUE;
                    mread_d = 1'b1;
                end
            end
            ST_WAIT_DATA: begin
                if (master_readdatavalid) begin
                    sum_d   = sum_q + master_readdata;
                    count_d = count_inc_s;
                    addr_d  = addr_q + 32'd4;
                    if (count_inc_s == length_q) begin
                        state_d = ST_DONE;
                        mread_d = 1'b0;
                    end else begin
                        state_d = ST_ISSUE;
                        mread_d = 1'b1;
                    end
                end else begin
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_DONE: begin
                irq_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                mread_d = 1'b0;
            end
        endcase
    end

    // Slave read mux; the result is captured one edge later.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_s) begin
            case (address)
                2'd0:    rdata_d = base_q;
                2'd1:    rdata_d = 32'(length_q);
                2'd2:    rdata_d = {30'd0, irq_q, busy_s};
                2'd3:    rdata_d = sum_q;
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            base_q   <= 32'd0;
            length_q <= LEN_ZERO;
            count_q  <= LEN_ZERO;
            sum_q    <= 32'd0;
            addr_q   <= 32'd0;
            mread_q  <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            length_q <= length_d;
            count_q  <= count_d;
            sum_q    <= sum_d;
            addr_q   <= addr_d;
            mread_q  <= mread_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
        end
    end

    assign readdata       = rdata_q;
    assign master_address = addr_q;
    assign master_read    = mread_q;
    assign done_irq       = irq_q;

endmodule
